sat_add_rr_scheduler: RTL and testbench

Shares one signed saturating adder between two requesters. Round-robin arbitration picks the requester, and the datapath computes the saturated sum. The result is held in a single output register with valid/ready backpressure. Per-requester saturation-event counters are kept for software and debug. The block sits between two operand producers and one result consumer in the combinational-arithmetic exercise chain, and turns the bare saturating adder into a schedulable shared resource.

---
 rtl/sat_add_pkg.sv | 25 ++
 rtl/signed_add_sat_core.sv | 31 +++
 rtl/sat_add_rr_scheduler.sv | 133 +++++++++++++
 tb/tb_sat_add_rr_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_add_pkg.sv
// Shared types and helpers for the round-robin saturating-adder scheduler.
package sat_add_pkg;

   typedef logic req_id_t;

   typedef enum logic {
      StEmpty,
      StFull
   } out_state_e;

   // Identity and saturation flag of a result; the sum width lives with the user.
   typedef struct packed {
      req_id_t id;
      logic    sat;
   } res_tag_t;

   function automatic int sat_max(input int width);
      return (1 << (width - 1)) - 1;
   endfunction

   function automatic int sat_min(input int width);
      return -(1 << (width - 1));
   endfunction

endpackage

// File: rtl/signed_add_sat_core.sv
// Combinational two's-complement adder that clamps to MAX/MIN on overflow.
module signed_add_sat_core
   import sat_add_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             sat
);

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(sat_max(WIDTH));
   localparam logic [WIDTH-1:0] MinVal = WIDTH'(sat_min(WIDTH));

   logic [WIDTH-1:0] raw;
   logic             ovf;

   always_comb begin
      raw = a + b;
      // Overflow only when both operands share a sign and the raw sum flips it.
      ovf = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
      sat = ovf;
      if (ovf) begin
         sum = a[WIDTH-1] ? MinVal : MaxVal;
      end else begin
         sum = raw;
      end
   end

endmodule

// File: rtl/sat_add_rr_scheduler.sv
// Two requesters share one saturating adder through a round-robin arbiter,
// a single valid/ready result register and per-requester saturation counters.
module sat_add_rr_scheduler
   import sat_add_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in0_valid,
   output logic             in0_ready,
   input  logic [WIDTH-1:0] in0_a,
   input  logic [WIDTH-1:0] in0_b,
   input  logic             in1_valid,
   output logic             in1_ready,
   input  logic [WIDTH-1:0] in1_a,
   input  logic [WIDTH-1:0] in1_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output req_id_t          out_id,
   output logic             out_sat,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] sat_cnt0,
   output logic [CNT_W-1:0] sat_cnt1
);

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      res_tag_t         tag;
   } res_t;

   out_state_e       state_q, state_d;
   res_t             res_q, res_d;
   req_id_t          rr_last_q, rr_last_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

   logic             grant0, grant1, slot_free, accept;
   req_id_t          acc_id;
   logic [WIDTH-1:0] op_a, op_b, core_sum;
   logic             core_sat;

   // Arbiter: a lone requester wins; under contention the one not served last wins.
   always_comb begin
      grant0    = in0_valid & (~in1_valid | rr_last_q);
      grant1    = in1_valid & (~in0_valid | ~rr_last_q);
      slot_free = (state_q == StEmpty) | out_ready;
      in0_ready = grant0 & slot_free;
      in1_ready = grant1 & slot_free;
      accept    = in0_ready | in1_ready;
      acc_id    = grant1;
      op_a      = grant1 ? in1_a : in0_a;
      op_b      = grant1 ? in1_b : in0_b;
   end

   signed_add_sat_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a   (op_a),
      .b   (op_b),
      .sum (core_sum),
      .sat (core_sat)
   );

   always_comb begin
      state_d   = state_q;
      res_d     = res_q;
      rr_last_d = rr_last_q;
      case (state_q)
         StEmpty: begin
            if (accept) begin
               state_d = StFull;
            end
         end
         StFull: begin
            if (!accept && out_ready) begin
               state_d = StEmpty;
            end
         end
         default: state_d = StEmpty;
      endcase
      if (accept) begin
         res_d.sum     = core_sum;
         res_d.tag.id  = acc_id;
         res_d.tag.sat = core_sat;
         rr_last_d     = acc_id;
      end
   end

   // Counters stick at all-ones; a clear overrides a same-cycle increment.
   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (cnt_clr) begin
         cnt0_d = '0;
         cnt1_d = '0;
      end else if (accept && core_sat) begin
         if (!acc_id && (cnt0_q != '1)) begin
            cnt0_d = cnt0_q + CNT_W'(1);
         end
         if (acc_id && (cnt1_q != '1)) begin
            cnt1_d = cnt1_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StEmpty;
         res_q     <= '0;
         rr_last_q <= 1'b1;
         cnt0_q    <= '0;
         cnt1_q    <= '0;
      end else begin
         state_q   <= state_d;
         res_q     <= res_d;
         rr_last_q <= rr_last_d;
         cnt0_q    <= cnt0_d;
         cnt1_q    <= cnt1_d;
      end
   end

   always_comb begin
      out_valid = (state_q == StFull);
      out_sum   = res_q.sum;
      out_id    = res_q.tag.id;
      out_sat   = res_q.tag.sat;
      sat_cnt0  = cnt0_q;
      sat_cnt1  = cnt1_q;
   end

endmodule

// File: tb/tb_sat_add_rr_scheduler.sv
// Randomized and directed bench for sat_add_rr_scheduler against an integer reference model.
module tb_sat_add_rr_scheduler;

   localparam int W    = 4;
   localparam int CW   = 8;
   localparam int MAXI = 2 ** (W - 1) - 1;
   localparam int MINI = -(2 ** (W - 1));
   localparam int CMAX = 2 ** CW - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in0_valid = 1'b0, in1_valid = 1'b0;
   logic          in0_ready, in1_ready;
   logic [W-1:0]  in0_a = '0, in0_b = '0, in1_a = '0, in1_b = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_sum;
   logic          out_id, out_sat;
   logic          cnt_clr = 1'b0;
   logic [CW-1:0] sat_cnt0, sat_cnt1;

   int vectors = 0;
   int errors  = 0;

   // Reference model state
   bit         m_valid;
   logic [W-1:0] m_sum;
   bit         m_id, m_sat, m_last;
   int         m_cnt[2];
   bit         e_rdy0, e_rdy1;

   sat_add_rr_scheduler #(
      .WIDTH (W),
      .CNT_W (CW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in0_valid (in0_valid),
      .in0_ready (in0_ready),
      .in0_a     (in0_a),
      .in0_b     (in0_b),
      .in1_valid (in1_valid),
      .in1_ready (in1_ready),
      .in1_a     (in1_a),
      .in1_b     (in1_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_id    (out_id),
      .out_sat   (out_sat),
      .cnt_clr   (cnt_clr),
      .sat_cnt0  (sat_cnt0),
      .sat_cnt1  (sat_cnt1)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog timeout vectors=%0d", vectors);
      $fatal(1, "timeout");
   end

   function automatic logic [W-1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                            output bit sat);
      int s;
      s   = int'($signed(a)) + int'($signed(b));
      sat = 1'b0;
      if (s > MAXI) begin
         s   = MAXI;
         sat = 1'b1;
      end else if (s < MINI) begin
         s   = MINI;
         sat = 1'b1;
      end
      return s[W-1:0];
   endfunction

   function automatic void model_reset();
      m_valid  = 1'b0;
      m_sum    = '0;
      m_id     = 1'b0;
      m_sat    = 1'b0;
      m_last   = 1'b1;
      m_cnt[0] = 0;
      m_cnt[1] = 0;
   endfunction

   function automatic void model_comb();
      bit free;
      int win;
      free = !m_valid || out_ready;
      if (in0_valid && in1_valid) win = m_last ? 0 : 1;
      else if (in0_valid)         win = 0;
      else if (in1_valid)         win = 1;
      else                        win = -1;
      e_rdy0 = free && (win == 0);
      e_rdy1 = free && (win == 1);
   endfunction

   function automatic void model_edge();
      bit sat;
      int id;
      model_comb();
      if (e_rdy0 || e_rdy1) begin
         id = e_rdy1 ? 1 : 0;
         if (id == 1) m_sum = ref_add(in1_a, in1_b, sat);
         else         m_sum = ref_add(in0_a, in0_b, sat);
         m_id    = id[0];
         m_sat   = sat;
         m_valid = 1'b1;
         m_last  = id[0];
         if (sat && m_cnt[id] < CMAX) m_cnt[id]++;
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
      if (cnt_clr) begin
         m_cnt[0] = 0;
         m_cnt[1] = 0;
      end
   endfunction

   task automatic settle();
      #1;
      model_comb();
   endtask

   task automatic edge_step();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
      vectors++; if (out_sum !== '0) begin errors++; $display("FAIL reset_sum got %h exp 0", out_sum); end
      vectors++; if (out_id !== 1'b0 || out_sat !== 1'b0) begin errors++; $display("FAIL reset_id_sat got %b%b exp 00", out_id, out_sat); end
      vectors++; if (sat_cnt0 !== '0 || sat_cnt1 !== '0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", sat_cnt0, sat_cnt1); end
      in0_valid = 1'b1;
      in1_valid = 1'b1;
      #1;
      vectors++; if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin errors++; $display("FAIL reset_grant got %b%b exp 10", in0_ready, in1_ready); end
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      rst_n = 1'b1;
      edge_step();
   endtask

   task automatic test_single();
      in0_a = 4'd4; in0_b = 4'd5; in0_valid = 1'b1;
      settle();
      vectors++; if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin errors++; $display("FAIL single_ready got %b%b exp 10", in0_ready, in1_ready); end
      edge_step();
      in0_valid = 1'b0;
      vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
      vectors++; if (out_sum !== 4'b0111 || out_sat !== 1'b1 || out_id !== 1'b0) begin
         errors++; $display("FAIL single_result got sum=%b sat=%b id=%b exp 0111/1/0", out_sum, out_sat, out_id); end
      vectors++; if (sat_cnt0 !== 8'd1) begin errors++; $display("FAIL single_cnt0 got %0d exp 1", sat_cnt0); end
      edge_step();
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", out_valid); end
   endtask

   task automatic test_req1();
      in1_a = 4'hC; in1_b = 4'hB; in1_valid = 1'b1;
      edge_step();
      vectors++; if (out_sum !== 4'b1000 || out_sat !== 1'b1 || out_id !== 1'b1) begin
         errors++; $display("FAIL neg_ovf got sum=%b sat=%b id=%b exp 1000/1/1", out_sum, out_sat, out_id); end
      in1_a = 4'd3; in1_b = 4'hE;
      edge_step();
      in1_valid = 1'b0;
      vectors++; if (out_valid !== 1'b1 || out_sum !== 4'b0001 || out_sat !== 1'b0 || out_id !== 1'b1) begin
         errors++; $display("FAIL no_ovf got v=%b sum=%b sat=%b id=%b exp 1/0001/0/1", out_valid, out_sum, out_sat, out_id); end
      vectors++; if (sat_cnt1 !== 8'd1) begin errors++; $display("FAIL req1_cnt1 got %0d exp 1", sat_cnt1); end
      edge_step();
   endtask

   task automatic test_contention();
      out_ready = 1'b1;
      in0_a = W'($urandom); in0_b = W'($urandom); in0_valid = 1'b1;
      in1_a = W'($urandom); in1_b = W'($urandom); in1_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         settle();
         vectors++; if (in0_ready !== (i % 2 == 0) || in1_ready !== (i % 2 == 1)) begin
            errors++; $display("FAIL cont_ready[%0d] got %b%b exp %b%b", i, in0_ready, in1_ready, i % 2 == 0, i % 2 == 1); end
         edge_step();
         vectors++; if (out_valid !== 1'b1 || out_id !== (i % 2 == 1) || out_sum !== m_sum) begin
            errors++; $display("FAIL cont_out[%0d] got v=%b id=%b sum=%h exp 1/%0d/%h", i, out_valid, out_id, out_sum, i % 2, m_sum); end
         if (i % 2 == 0) begin in0_a = W'($urandom); in0_b = W'($urandom); end
         else            begin in1_a = W'($urandom); in1_b = W'($urandom); end
      end
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      edge_step();
   endtask

   task automatic test_backpressure();
      in0_a = 4'd1; in0_b = 4'd2; in0_valid = 1'b1;
      edge_step();
      out_ready = 1'b0;
      in0_a = 4'd2; in0_b = 4'd2;
      in1_a = 4'd5; in1_b = 4'hF; in1_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         settle();
         vectors++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
            errors++; $display("FAIL bp_ready[%0d] got %b%b exp 00", k, in0_ready, in1_ready); end
         edge_step();
         vectors++; if (out_valid !== 1'b1 || out_sum !== 4'd3 || out_id !== 1'b0 || out_sat !== 1'b0) begin
            errors++; $display("FAIL bp_hold[%0d] got v=%b sum=%h id=%b sat=%b exp 1/3/0/0", k, out_valid, out_sum, out_id, out_sat); end
      end
      out_ready = 1'b1;
      settle();
      vectors++; if (in0_ready !== 1'b0 || in1_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release_ready got %b%b exp 01", in0_ready, in1_ready); end
      edge_step();
      in1_valid = 1'b0;
      vectors++; if (out_valid !== 1'b1 || out_sum !== 4'd4 || out_id !== 1'b1) begin
         errors++; $display("FAIL bp_new got v=%b sum=%h id=%b exp 1/4/1", out_valid, out_sum, out_id); end
      edge_step();
      in0_valid = 1'b0;
      edge_step();
   endtask

   task automatic test_counter_limit();
      cnt_clr = 1'b1;
      edge_step();
      cnt_clr = 1'b0;
      vectors++; if (sat_cnt0 !== '0 || sat_cnt1 !== '0) begin
         errors++; $display("FAIL clr got %0d/%0d exp 0/0", sat_cnt0, sat_cnt1); end
      in0_a = 4'd4; in0_b = 4'd5; in0_valid = 1'b1;
      repeat (260) edge_step();
      vectors++; if (sat_cnt0 !== 8'd255) begin errors++; $display("FAIL cnt_limit got %0d exp 255", sat_cnt0); end
      cnt_clr = 1'b1;
      edge_step();
      cnt_clr = 1'b0;
      vectors++; if (sat_cnt0 !== 8'd0 || out_sat !== 1'b1) begin
         errors++; $display("FAIL clr_wins got cnt=%0d sat=%b exp 0/1", sat_cnt0, out_sat); end
      in0_valid = 1'b0;
      edge_step();
   endtask

   task automatic test_random();
      bit acc0, acc1;
      for (int n = 0; n < 400; n++) begin
         if (!in0_valid && $urandom_range(0, 1) == 1) begin
            in0_a = W'($urandom); in0_b = W'($urandom); in0_valid = 1'b1;
         end
         if (!in1_valid && $urandom_range(0, 1) == 1) begin
            in1_a = W'($urandom); in1_b = W'($urandom); in1_valid = 1'b1;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         cnt_clr   = ($urandom_range(0, 31) == 0);
         settle();
         vectors++; if (in0_ready !== e_rdy0 || in1_ready !== e_rdy1) begin
            errors++; $display("FAIL rnd_ready[%0d] got %b%b exp %b%b", n, in0_ready, in1_ready, e_rdy0, e_rdy1); end
         acc0 = e_rdy0;
         acc1 = e_rdy1;
         edge_step();
         vectors++; if (out_valid !== m_valid ||
                        (m_valid && (out_sum !== m_sum || out_id !== m_id || out_sat !== m_sat))) begin
            errors++; $display("FAIL rnd_out[%0d] got v=%b sum=%h id=%b sat=%b exp %b/%h/%b/%b",
                               n, out_valid, out_sum, out_id, out_sat, m_valid, m_sum, m_id, m_sat); end
         vectors++; if (int'(sat_cnt0) != m_cnt[0] || int'(sat_cnt1) != m_cnt[1]) begin
            errors++; $display("FAIL rnd_cnt[%0d] got %0d/%0d exp %0d/%0d", n, sat_cnt0, sat_cnt1, m_cnt[0], m_cnt[1]); end
         if (acc0) in0_valid = 1'b0;
         if (acc1) in1_valid = 1'b0;
      end
      cnt_clr   = 1'b0;
      out_ready = 1'b1;
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      edge_step();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in0_a = 4'd4; in0_b = 4'd5; in0_valid = 1'b1;
      edge_step();
      in0_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      vectors++; if (out_valid !== 1'b0 || sat_cnt0 !== '0 || sat_cnt1 !== '0 || out_sum !== '0) begin
         errors++; $display("FAIL mid_reset got v=%b cnt=%0d/%0d sum=%h exp 0/0/0/0", out_valid, sat_cnt0, sat_cnt1, out_sum); end
      in0_a = 4'd1; in0_b = 4'd1; in0_valid = 1'b1;
      in1_a = 4'd2; in1_b = 4'd2; in1_valid = 1'b1;
      rst_n = 1'b1;
      settle();
      vectors++; if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
         errors++; $display("FAIL post_reset_grant got %b%b exp 10", in0_ready, in1_ready); end
      edge_step();
      vectors++; if (out_valid !== 1'b1 || out_id !== 1'b0 || out_sum !== 4'd2) begin
         errors++; $display("FAIL post_reset_out got v=%b id=%b sum=%h exp 1/0/2", out_valid, out_id, out_sum); end
      in0_valid = 1'b0;
      in1_valid = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_req1();
      test_contention();
      test_backpressure();
      test_counter_limit();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
